multicycle_alu: RTL

Parametrised, clocked successor to the combinational datapath ALU. Adds a START/BUSY/DONE handshake, a registered result, carry-chained add/subtract, and iterative multiply and divide in a dedicated sub-unit. Sits between the register file read ports and the writeback mux. The control FSM stalls fetch while BUSY is high.

---
 rtl/malu_pkg.sv | 30 +++
 rtl/seq_muldiv.sv | 69 ++++++
 rtl/multicycle_alu.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/malu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and
// the helper that tells single-cycle ops from iterative ones.
package malu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        LSH   = 4'd5,
        RSH   = 4'd6,
        PASSA = 4'd7,
        PASSB = 4'd8,
        MULLO = 4'd9,
        MULHI = 4'd10,
        DIV   = 4'd11,
        MOD   = 4'd12
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_multicycle(alu_op_t op);
        return (op == MULLO) || (op == MULHI) || (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
// lo/hi present the result of the step being taken, so they are final while last is high.
module seq_muldiv #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         load,
    input  logic         mode,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         last
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opnd_q;
    logic           mode_q;
    logic           active_q;
    logic [CW-1:0]  cnt_q;

    logic [W:0]   mulSum;
    logic [W:0]   divShift;
    logic [W-1:0] divTrial;
    logic         divGe;

    // mul: acc = {partial, multiplier}; div: acc = {remainder, quotient/dividend}
    always_comb begin
        mulSum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        divShift = {acc_q[2*W-1:W], acc_q[W-1]};
        divGe    = divShift[W] || (divShift[W-1:0] >= opnd_q);
        divTrial = divShift[W-1:0] - opnd_q;
        if (mode_q) begin
            acc_d = {(divGe ? divTrial : divShift[W-1:0]), acc_q[W-2:0], divGe};
        end else begin
            acc_d = {mulSum, acc_q[W-1:1]};
        end
    end

    assign lo   = acc_d[W-1:0];
    assign hi   = acc_d[2*W-1:W];
    assign last = active_q && (cnt_q == CW'(W - 1));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            mode_q   <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_q    <= mode ? {{W{1'b0}}, A} : {{W{1'b0}}, B};
            opnd_q   <= mode ? B : A;
            mode_q   <= mode;
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Clocked ALU with START/BUSY/DONE handshake: logic/arith/shift ops finish in one
// cycle, multiply/divide run W iterations in seq_muldiv.
module multicycle_alu
    import malu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         START,
    input  logic [3:0]   OP,
    input  logic [W-1:0] INPUTA,
    input  logic [W-1:0] INPUTB,
    input  logic         SC_IN,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] OUT,
    output logic         SC_OUT,
    output logic         ZERO,
    output logic         DIV_BY_ZERO
);

    localparam logic [W-1:0] SHIFT_LIMIT = W'(W);

    state_t       state_q, state_d;
    alu_op_t      op_q, op_d;
    logic         bzero_q, bzero_d;
    logic [W-1:0] out_q, out_d;
    logic         sc_q, sc_d;
    logic         zero_q, zero_d;
    logic         dbz_q, dbz_d;
    logic         done_q, done_d;

    alu_op_t      opIn;
    logic         load;
    logic         divMode;
    logic         last;
    logic [W-1:0] mdLo, mdHi, mdRes;
    logic [W:0]   addSum, subDiff;
    logic [W-1:0] singleRes;
    logic         singleSc;

    assign opIn    = alu_op_t'(OP);
    assign divMode = (opIn == DIV) || (opIn == MOD);
    assign addSum  = {1'b0, INPUTA} + {1'b0, INPUTB} + {{W{1'b0}}, SC_IN};
    assign subDiff = {1'b0, INPUTA} - {1'b0, INPUTB} - {{W{1'b0}}, SC_IN};

    seq_muldiv #(.W(W)) u_muldiv (
        .CLK   (CLK),
        .Reset (Reset),
        .load  (load),
        .mode  (divMode),
        .A     (INPUTA),
        .B     (INPUTB),
        .lo    (mdLo),
        .hi    (mdHi),
        .last  (last)
    );

    always_comb begin
        singleRes = '0;
        singleSc  = 1'b0;
        case (opIn)
            ADD:     begin singleRes = addSum[W-1:0];  singleSc = addSum[W];  end
            SUB:     begin singleRes = subDiff[W-1:0]; singleSc = subDiff[W]; end
            AND:     singleRes = INPUTA & INPUTB;
            OR:      singleRes = INPUTA | INPUTB;
            XOR:     singleRes = INPUTA ^ INPUTB;
            LSH:     singleRes = (INPUTB >= SHIFT_LIMIT) ? '0 : (INPUTA << INPUTB);
            RSH:     singleRes = (INPUTB >= SHIFT_LIMIT) ? '0 : (INPUTA >> INPUTB);
            PASSA:   singleRes = INPUTA;
            PASSB:   singleRes = INPUTB;
            default: singleRes = '0;
        endcase
    end

    // division by zero needs no special path: the restoring loop yields all-ones / A
    always_comb begin
        case (op_q)
            MULLO:   mdRes = mdLo;
            DIV:     mdRes = mdLo;
            default: mdRes = mdHi;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        bzero_d = bzero_q;
        out_d   = out_q;
        sc_d    = sc_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (is_multicycle(opIn)) begin
                        load    = 1'b1;
                        op_d    = opIn;
                        bzero_d = (INPUTB == '0);
                        state_d = RUN;
                    end else begin
                        out_d  = singleRes;
                        sc_d   = singleSc;
                        zero_d = (singleRes == '0);
                        dbz_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last) begin
                    out_d   = mdRes;
                    sc_d    = 1'b0;
                    zero_d  = (mdRes == '0);
                    dbz_d   = bzero_q && ((op_q == DIV) || (op_q == MOD));
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= ADD;
            bzero_q <= 1'b0;
            out_q   <= '0;
            sc_q    <= 1'b0;
            zero_q  <= 1'b1;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bzero_q <= bzero_d;
            out_q   <= out_d;
            sc_q    <= sc_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign BUSY        = (state_q == RUN);
    assign DONE        = done_q;
    assign OUT         = out_q;
    assign SC_OUT      = sc_q;
    assign ZERO        = zero_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule
